gci_std_display_vram_arbiter: RTL and testbench

Responder end of the VRAM arbitration/access protocol. It grants one of two VRAM masters exclusive use of the single VRAM memory port: master 0 is the display-controller VRAM interface and master 1 is a second agent such as a blitter or CPU bridge. It answers REQ/ACK/FINISH and muxes the owner's ENA/RW/ADDR/DATA onto the memory port. Read data returns to the owner, and the block holds ownership until every outstanding read has returned.

---
 rtl/gci_std_display_pkg.sv | 20 ++
 rtl/gci_std_display_vram_arbiter_rr_pick.sv | 18 +
 rtl/gci_std_display_vram_arbiter.sv | 156 +++++++++++++++
 tb/tb_gci_std_display_vram_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gci_std_display_pkg.sv
// Shared encodings for the display VRAM arbiter: FSM state codes and the
// command RW polarity used on both master and memory ports.
package gci_std_display_pkg;

  localparam logic [1:0] L_PARAM_ST_IDLE   = 2'd0;
  localparam logic [1:0] L_PARAM_ST_GRANT0 = 2'd1;
  localparam logic [1:0] L_PARAM_ST_GRANT1 = 2'd2;
  localparam logic [1:0] L_PARAM_ST_DRAIN  = 2'd3;

  localparam logic L_PARAM_RW_WRITE = 1'b1;
  localparam logic L_PARAM_RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = L_PARAM_ST_IDLE,
    ST_GRANT0 = L_PARAM_ST_GRANT0,
    ST_GRANT1 = L_PARAM_ST_GRANT1,
    ST_DRAIN  = L_PARAM_ST_DRAIN
  } arbit_state_t;

endpackage

// File: rtl/gci_std_display_vram_arbiter_rr_pick.sv
// Two-way round-robin pick: on a tie the master that was not granted last wins.
module gci_std_display_vram_rr_pick (
  input  logic [1:0] iREQ,
  input  logic       iLAST,
  output logic       oGRANT,
  output logic       oVALID
);

  always_comb begin
    oVALID = |iREQ;
    if (&iREQ) begin
      oGRANT = ~iLAST;
    end else begin
      oGRANT = iREQ[1];
    end
  end

endmodule

// File: rtl/gci_std_display_vram_arbiter.sv
// VRAM port arbiter: grants one of two masters, muxes its commands onto the
// memory port and keeps ownership until all of its reads have returned.
module gci_std_display_vram_arbiter
  import gci_std_display_pkg::*;
#(
  parameter int P_MEM_ADDR_N = 19,
  parameter int P_OUTST_N    = 4
)(
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  input  logic                    iRESET_SYNC,
  input  logic                    iM0_ARBIT_REQ,
  output logic                    oM0_ARBIT_ACK,
  input  logic                    iM0_ARBIT_FINISH,
  input  logic                    iM0_ENA,
  output logic                    oM0_BUSY,
  input  logic                    iM0_RW,
  input  logic [P_MEM_ADDR_N-1:0] iM0_ADDR,
  input  logic [31:0]             iM0_DATA,
  output logic                    oM0_VALID,
  input  logic                    iM0_BUSY,
  output logic [31:0]             oM0_DATA,
  input  logic                    iM1_ARBIT_REQ,
  output logic                    oM1_ARBIT_ACK,
  input  logic                    iM1_ARBIT_FINISH,
  input  logic                    iM1_ENA,
  output logic                    oM1_BUSY,
  input  logic                    iM1_RW,
  input  logic [P_MEM_ADDR_N-1:0] iM1_ADDR,
  input  logic [31:0]             iM1_DATA,
  output logic                    oM1_VALID,
  input  logic                    iM1_BUSY,
  output logic [31:0]             oM1_DATA,
  output logic                    oMEM_ENA,
  output logic                    oMEM_RW,
  output logic [P_MEM_ADDR_N-1:0] oMEM_ADDR,
  output logic [31:0]             oMEM_DATA,
  input  logic                    iMEM_BUSY,
  input  logic                    iMEM_VALID,
  input  logic [31:0]             iMEM_DATA,
  output logic                    oMEM_BUSY
);

  arbit_state_t         bState;
  logic                 bOwner;
  logic                 bLast;
  logic                 bAck0;
  logic                 bAck1;
  logic [P_OUTST_N-1:0] bOutst;
  logic [P_OUTST_N-1:0] outstNext;

  logic pickGrant, pickValid;
  logic grant0, grant1, outstFull, outstZero;
  logic selEna, selRw, readStall, incr, decr, finish;

  gci_std_display_vram_rr_pick uPick (
    .iREQ   ({iM1_ARBIT_REQ, iM0_ARBIT_REQ}),
    .iLAST  (bLast),
    .oGRANT (pickGrant),
    .oVALID (pickValid)
  );

  assign grant0    = (bState == ST_GRANT0);
  assign grant1    = (bState == ST_GRANT1);
  assign outstFull = &bOutst;
  assign outstZero = (bOutst == '0);

  always_comb begin
    selEna    = 1'b0;
    selRw     = L_PARAM_RW_READ;
    oMEM_ADDR = iM0_ADDR;
    oMEM_DATA = iM0_DATA;
    if (grant1) begin
      selEna    = iM1_ENA;
      selRw     = iM1_RW;
      oMEM_ADDR = iM1_ADDR;
      oMEM_DATA = iM1_DATA;
    end else if (grant0) begin
      selEna    = iM0_ENA;
      selRw     = iM0_RW;
    end
  end

  // A full counter stalls only reads; writes keep flowing.
  assign readStall = (selRw == L_PARAM_RW_READ) & outstFull;
  assign oMEM_ENA  = selEna & ~readStall;
  assign oMEM_RW   = selRw;
  assign oM0_BUSY  = grant0 ? (iMEM_BUSY | readStall) : 1'b1;
  assign oM1_BUSY  = grant1 ? (iMEM_BUSY | readStall) : 1'b1;

  assign oMEM_BUSY = ~outstZero & (bOwner ? iM1_BUSY : iM0_BUSY);
  assign oM0_VALID = iMEM_VALID & ~outstZero & ~bOwner;
  assign oM1_VALID = iMEM_VALID & ~outstZero & bOwner;
  assign oM0_DATA  = iMEM_DATA;
  assign oM1_DATA  = iMEM_DATA;

  assign incr   = oMEM_ENA & ~iMEM_BUSY & (selRw == L_PARAM_RW_READ);
  assign decr   = iMEM_VALID & ~outstZero & ~oMEM_BUSY;
  assign finish = (grant0 & iM0_ARBIT_FINISH) | (grant1 & iM1_ARBIT_FINISH);

  always_comb begin
    case ({incr, decr})
      2'b10:   outstNext = bOutst + 1'b1;
      2'b01:   outstNext = bOutst - 1'b1;
      default: outstNext = bOutst;
    endcase
  end

  assign oM0_ARBIT_ACK = bAck0;
  assign oM1_ARBIT_ACK = bAck1;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      bState <= ST_IDLE;
      bOwner <= 1'b0;
      bLast  <= 1'b1;
      bAck0  <= 1'b0;
      bAck1  <= 1'b0;
      bOutst <= '0;
    end else if (iRESET_SYNC) begin
      bState <= ST_IDLE;
      bOwner <= 1'b0;
      bLast  <= 1'b1;
      bAck0  <= 1'b0;
      bAck1  <= 1'b0;
      bOutst <= '0;
    end else begin
      bOutst <= outstNext;
      bAck0  <= 1'b0;
      bAck1  <= 1'b0;
      case (bState)
        ST_IDLE: begin
          if (pickValid) begin
            bState <= pickGrant ? ST_GRANT1 : ST_GRANT0;
            bOwner <= pickGrant;
            bLast  <= pickGrant;
            bAck0  <= ~pickGrant;
            bAck1  <= pickGrant;
          end
        end
        ST_GRANT0, ST_GRANT1: begin
          if (finish) begin
            bState <= (outstNext == '0) ? ST_IDLE : ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (outstNext == '0) begin
            bState <= ST_IDLE;
          end
        end
        default: bState <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gci_std_display_vram_arbiter.sv
// Bench for the VRAM arbiter: a table of directed cycles, hand-written
// corner sequences and a random phase, all checked against an ownership model.
module tb_gci_std_display_vram_arbiter;

  localparam int AW   = 19;
  localparam int MAXO = 15;

  logic iCLOCK = 1'b0;
  logic inRESET;
  logic iRESET_SYNC;
  logic iM0_ARBIT_REQ, oM0_ARBIT_ACK, iM0_ARBIT_FINISH, iM0_ENA, oM0_BUSY, iM0_RW;
  logic iM1_ARBIT_REQ, oM1_ARBIT_ACK, iM1_ARBIT_FINISH, iM1_ENA, oM1_BUSY, iM1_RW;
  logic [AW-1:0] iM0_ADDR, iM1_ADDR, oMEM_ADDR;
  logic [31:0] iM0_DATA, iM1_DATA, oM0_DATA, oM1_DATA, oMEM_DATA, iMEM_DATA;
  logic oM0_VALID, iM0_BUSY, oM1_VALID, iM1_BUSY;
  logic oMEM_ENA, oMEM_RW, iMEM_BUSY, iMEM_VALID, oMEM_BUSY;

  always #5 iCLOCK = ~iCLOCK;

  gci_std_display_vram_arbiter #(.P_MEM_ADDR_N(AW), .P_OUTST_N(4)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iM0_ARBIT_REQ(iM0_ARBIT_REQ), .oM0_ARBIT_ACK(oM0_ARBIT_ACK),
    .iM0_ARBIT_FINISH(iM0_ARBIT_FINISH), .iM0_ENA(iM0_ENA), .oM0_BUSY(oM0_BUSY),
    .iM0_RW(iM0_RW), .iM0_ADDR(iM0_ADDR), .iM0_DATA(iM0_DATA), .oM0_VALID(oM0_VALID),
    .iM0_BUSY(iM0_BUSY), .oM0_DATA(oM0_DATA),
    .iM1_ARBIT_REQ(iM1_ARBIT_REQ), .oM1_ARBIT_ACK(oM1_ARBIT_ACK),
    .iM1_ARBIT_FINISH(iM1_ARBIT_FINISH), .iM1_ENA(iM1_ENA), .oM1_BUSY(oM1_BUSY),
    .iM1_RW(iM1_RW), .iM1_ADDR(iM1_ADDR), .iM1_DATA(iM1_DATA), .oM1_VALID(oM1_VALID),
    .iM1_BUSY(iM1_BUSY), .oM1_DATA(oM1_DATA),
    .oMEM_ENA(oMEM_ENA), .oMEM_RW(oMEM_RW), .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA),
    .iMEM_BUSY(iMEM_BUSY), .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA),
    .oMEM_BUSY(oMEM_BUSY)
  );

  typedef struct {
    logic          sync;
    logic [1:0]    req, fin, ena, rw, mbusy;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   data0, data1;
    logic          memBusy, memValid;
    logic [31:0]   memData;
  } in_t;

  typedef struct {
    in_t           in;
    logic          ack0, ack1, ena, busy0, busy1;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Ownership model: who holds the port, whether it is draining, reads in flight.
  bit   mOwned, mDrain, mOwner, mLast;
  bit   [1:0] mAck;
  int   mOut;
  int   eGrant;
  logic eMemEna, eMemBusy;
  logic [1:0] eBusy, eValid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t blank();
    in_t v;
    v.sync = 0; v.req = 0; v.fin = 0; v.ena = 0; v.rw = 0; v.mbusy = 0;
    v.addr0 = 19'h00010; v.addr1 = 19'h2ABCD;
    v.data0 = 32'hDEADBEEF; v.data1 = 32'h12345678;
    v.memBusy = 0; v.memValid = 0; v.memData = 32'hA5A50000;
    return v;
  endfunction

  function automatic in_t mkv(logic sync, logic [1:0] req, logic [1:0] fin,
                              logic [1:0] ena, logic [1:0] rw);
    in_t v;
    v = blank();
    v.sync = sync; v.req = req; v.fin = fin; v.ena = ena; v.rw = rw;
    return v;
  endfunction

  task automatic model_reset();
    mOwned = 0; mDrain = 0; mOwner = 0; mLast = 1; mAck = 0; mOut = 0;
  endtask

  task automatic model_comb(input in_t v);
    logic stall;
    eGrant  = (mOwned && !mDrain) ? int'(mOwner) : -1;
    eMemEna = 0;
    eBusy   = 2'b11;
    if (eGrant >= 0) begin
      stall = (v.rw[eGrant] == 1'b0) && (mOut == MAXO);
      eBusy[eGrant] = v.memBusy | stall;
      eMemEna = v.ena[eGrant] & ~stall;
    end
    eMemBusy = (mOut != 0) && v.mbusy[mOwner];
    for (int n = 0; n < 2; n++) eValid[n] = v.memValid && (mOut != 0) && (int'(mOwner) == n);
  endtask

  task automatic model_update(input in_t v);
    int inc, dec, newOut;
    bit w;
    if (v.sync) begin
      model_reset();
      return;
    end
    inc = (eMemEna && !v.memBusy && v.rw[eGrant] == 1'b0) ? 1 : 0;
    dec = (v.memValid && mOut != 0 && !eMemBusy) ? 1 : 0;
    newOut = mOut + inc - dec;
    mAck = 0;
    if (!mOwned) begin
      if (v.req != 0) begin
        w = (v.req == 2'b11) ? !mLast : v.req[1];
        mOwned = 1; mDrain = 0; mOwner = w; mLast = w; mAck[w] = 1;
      end
    end else if (!mDrain) begin
      if (v.fin[mOwner]) begin
        if (newOut == 0) mOwned = 0;
        else mDrain = 1;
      end
    end else if (newOut == 0) begin
      mOwned = 0; mDrain = 0;
    end
    mOut = newOut;
  endtask

  task automatic apply(input in_t v);
    iRESET_SYNC = v.sync;
    iM0_ARBIT_REQ = v.req[0]; iM1_ARBIT_REQ = v.req[1];
    iM0_ARBIT_FINISH = v.fin[0]; iM1_ARBIT_FINISH = v.fin[1];
    iM0_ENA = v.ena[0]; iM1_ENA = v.ena[1];
    iM0_RW = v.rw[0]; iM1_RW = v.rw[1];
    iM0_ADDR = v.addr0; iM1_ADDR = v.addr1;
    iM0_DATA = v.data0; iM1_DATA = v.data1;
    iM0_BUSY = v.mbusy[0]; iM1_BUSY = v.mbusy[1];
    iMEM_BUSY = v.memBusy; iMEM_VALID = v.memValid; iMEM_DATA = v.memData;
  endtask

  task automatic check_model(input in_t v);
    model_comb(v);
    chk("ack0", oM0_ARBIT_ACK, mAck[0]);
    chk("ack1", oM1_ARBIT_ACK, mAck[1]);
    chk("busy0", oM0_BUSY, eBusy[0]);
    chk("busy1", oM1_BUSY, eBusy[1]);
    chk("valid0", oM0_VALID, eValid[0]);
    chk("valid1", oM1_VALID, eValid[1]);
    chk("mem_ena", oMEM_ENA, eMemEna);
    chk("mem_busy", oMEM_BUSY, eMemBusy);
    chk("rdata0", oM0_DATA, v.memData);
    chk("rdata1", oM1_DATA, v.memData);
    if (eGrant >= 0) begin
      chk("mem_rw", oMEM_RW, v.rw[eGrant]);
      chk("mem_addr", 32'(oMEM_ADDR), 32'((eGrant == 1) ? v.addr1 : v.addr0));
      chk("mem_data", oMEM_DATA, (eGrant == 1) ? v.data1 : v.data0);
    end
  endtask

  task automatic pre(input in_t v);
    apply(v);
    #2;
    check_model(v);
  endtask

  task automatic post(input in_t v);
    @(posedge iCLOCK);
    #1;
    model_update(v);
  endtask

  task automatic cycle(input in_t v);
    pre(v);
    post(v);
  endtask

  vec_t tab [14];

  initial begin
    in_t v;
    int  nValid, ackAt;
    bit  [1:0] rq;

    tab[0]  = '{mkv(0, 2'b01, 2'b00, 2'b00, 2'b00), 0, 0, 0, 1, 1, 19'h0, 32'h0};
    tab[1]  = '{mkv(0, 2'b00, 2'b00, 2'b01, 2'b01), 1, 0, 1, 0, 1, 19'h00010, 32'hDEADBEEF};
    tab[2]  = '{mkv(0, 2'b00, 2'b01, 2'b00, 2'b00), 0, 0, 0, 0, 1, 19'h0, 32'h0};
    tab[3]  = '{mkv(1, 2'b00, 2'b00, 2'b00, 2'b00), 0, 0, 0, 1, 1, 19'h0, 32'h0};
    tab[4]  = '{mkv(0, 2'b11, 2'b00, 2'b00, 2'b00), 0, 0, 0, 1, 1, 19'h0, 32'h0};
    tab[5]  = '{mkv(0, 2'b11, 2'b00, 2'b00, 2'b00), 1, 0, 0, 0, 1, 19'h0, 32'h0};
    tab[6]  = '{mkv(0, 2'b11, 2'b01, 2'b00, 2'b00), 0, 0, 0, 0, 1, 19'h0, 32'h0};
    tab[7]  = '{mkv(0, 2'b11, 2'b00, 2'b00, 2'b00), 0, 0, 0, 1, 1, 19'h0, 32'h0};
    tab[8]  = '{mkv(0, 2'b11, 2'b00, 2'b00, 2'b00), 0, 1, 0, 1, 0, 19'h0, 32'h0};
    tab[9]  = '{mkv(0, 2'b11, 2'b10, 2'b00, 2'b00), 0, 0, 0, 1, 0, 19'h0, 32'h0};
    tab[10] = '{mkv(0, 2'b11, 2'b00, 2'b00, 2'b00), 0, 0, 0, 1, 1, 19'h0, 32'h0};
    tab[11] = '{mkv(0, 2'b11, 2'b00, 2'b00, 2'b00), 1, 0, 0, 0, 1, 19'h0, 32'h0};
    tab[12] = '{mkv(0, 2'b00, 2'b01, 2'b00, 2'b00), 0, 0, 0, 0, 1, 19'h0, 32'h0};
    tab[13] = '{mkv(0, 2'b00, 2'b00, 2'b00, 2'b00), 0, 0, 0, 1, 1, 19'h0, 32'h0};

    inRESET = 1'b0;
    model_reset();
    v = blank();
    pre(v);
    @(posedge iCLOCK);
    @(posedge iCLOCK);
    #1;
    inRESET = 1'b1;

    // Single master, then the tie sequence M0 -> M1 -> M0.
    for (int i = 0; i < 14; i++) begin
      pre(tab[i].in);
      chk($sformatf("tab%0d_ack0", i), oM0_ARBIT_ACK, tab[i].ack0);
      chk($sformatf("tab%0d_ack1", i), oM1_ARBIT_ACK, tab[i].ack1);
      chk($sformatf("tab%0d_mem_ena", i), oMEM_ENA, tab[i].ena);
      chk($sformatf("tab%0d_busy0", i), oM0_BUSY, tab[i].busy0);
      chk($sformatf("tab%0d_busy1", i), oM1_BUSY, tab[i].busy1);
      if (tab[i].ena) begin
        chk($sformatf("tab%0d_addr", i), 32'(oMEM_ADDR), 32'(tab[i].addr));
        chk($sformatf("tab%0d_data", i), oMEM_DATA, tab[i].data);
      end
      post(tab[i].in);
    end

    // Drain: M1 reads three times, finishes with the last, returns trickle in.
    v = blank(); v.sync = 1; cycle(v);
    v = blank(); v.req = 2'b10; cycle(v);
    for (int r = 0; r < 3; r++) begin
      v = blank(); v.ena = 2'b10; v.rw = 2'b00; v.addr1 = 19'(r + 5);
      v.fin = (r == 2) ? 2'b10 : 2'b00;
      cycle(v);
    end
    nValid = 0; ackAt = -1;
    for (int k = 1; k <= 14; k++) begin
      v = blank();
      v.memValid = (k == 2 || k == 5 || k == 9);
      v.memData = 32'(k);
      v.req = (k <= 11) ? 2'b01 : 2'b00;
      v.fin = (k == 12) ? 2'b01 : 2'b00;
      pre(v);
      if (oM1_VALID === 1'b1) nValid++;
      if (oM0_ARBIT_ACK === 1'b1 && ackAt < 0) ackAt = k;
      post(v);
    end
    chk("drain_valid_pulses", nValid, 3);
    chk("drain_next_ack_cycle", ackAt, 11);

    // Back-pressure and counter-full behaviour on M0.
    v = blank(); v.sync = 1; cycle(v);
    v = blank(); v.req = 2'b01; cycle(v);
    v = blank(); v.ena = 2'b01; v.rw = 2'b01; v.memBusy = 1;
    pre(v); chk("mem_busy_stalls_m0", oM0_BUSY, 1); post(v);
    v = blank(); v.ena = 2'b01; v.memBusy = 1; cycle(v);
    v = blank(); v.memValid = 1;
    pre(v); chk("unaccepted_read_no_valid", oM0_VALID, 0); post(v);
    v = blank(); v.ena = 2'b01; cycle(v);
    for (int k = 0; k < 2; k++) begin
      v = blank(); v.memValid = 1; v.mbusy = 2'b01;
      pre(v); chk("m0_busy_backpressure", oMEM_BUSY, 1); post(v);
    end
    v = blank(); v.memValid = 1; cycle(v);
    v = blank(); v.memValid = 1;
    pre(v); chk("underflow_valid0", oM0_VALID, 0); chk("underflow_valid1", oM1_VALID, 0); post(v);
    for (int k = 0; k < MAXO; k++) begin
      v = blank(); v.ena = 2'b01; v.addr0 = 19'(k); cycle(v);
    end
    v = blank(); v.ena = 2'b01;
    pre(v); chk("full_read_stalled", oMEM_ENA, 0); chk("full_read_busy", oM0_BUSY, 1); post(v);
    v = blank(); v.ena = 2'b01; v.rw = 2'b01;
    pre(v); chk("full_write_passes", oMEM_ENA, 1); chk("full_write_busy", oM0_BUSY, 0); post(v);
    v = blank(); v.memValid = 1; cycle(v);
    v = blank(); v.memValid = 1; v.ena = 2'b01; cycle(v);
    v = blank(); v.ena = 2'b01;
    pre(v); chk("simul_read_accepted", oMEM_ENA, 1); post(v);
    v = blank(); v.ena = 2'b01;
    pre(v); chk("simul_kept_count", oMEM_ENA, 0); post(v);
    v = blank(); v.memValid = 1; v.fin = 2'b01; cycle(v);
    for (int k = 0; k < MAXO - 1; k++) begin
      v = blank(); v.memValid = 1; cycle(v);
    end

    // Synchronous clear while M1 has two reads outstanding.
    v = blank(); v.req = 2'b10; cycle(v);
    v = blank(); v.ena = 2'b10; cycle(v);
    v = blank(); v.ena = 2'b10; cycle(v);
    v = blank(); v.sync = 1; cycle(v);
    for (int k = 0; k < 2; k++) begin
      v = blank(); v.memValid = 1;
      pre(v);
      chk("sync_late_valid1", oM1_VALID, 0);
      chk("sync_ack1", oM1_ARBIT_ACK, 0);
      chk("sync_idle_busy1", oM1_BUSY, 1);
      chk("sync_mem_busy", oMEM_BUSY, 0);
      post(v);
    end

    // Random traffic with masters obeying hold-REQ-until-ACK.
    rq = 0;
    for (int c = 0; c < 3000; c++) begin
      v = blank();
      for (int n = 0; n < 2; n++) begin
        if (!rq[n] && ($urandom_range(0, 5) == 0)) rq[n] = 1;
      end
      v.req = rq;
      v.ena = 2'($urandom);
      v.rw = 2'($urandom);
      v.fin = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
      v.mbusy = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      v.addr0 = 19'($urandom); v.addr1 = 19'($urandom);
      v.data0 = $urandom; v.data1 = $urandom;
      v.memBusy = ($urandom_range(0, 3) == 0);
      v.memValid = ($urandom_range(0, 2) == 0);
      v.memData = $urandom;
      v.sync = ($urandom_range(0, 199) == 0);
      cycle(v);
      for (int n = 0; n < 2; n++) if (mAck[n]) rq[n] = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
